main_mem_responder: RTL and testbench
=====================================

Name: main_mem_responder

Overview:
- Next-level memory model that sits on the miss side of cache_top.
- Accepts block read (fill) and write (write-back / write-through) requests from the cache controller over a valid/ready handshake.
- Returns a response after a fixed, parameterised latency.
- Holds a small direct-indexed backing store and counts memory reads and writes, so trace runs can report memory traffic next to cache hit/miss statistics.

Parameters:
- ADDR_W, 48, request address width (matches cache_addr).
- DATA_W, 64, block data width per request.
- BLOCK_OFFSET, 6, address bits below the block index (64 B block).
- IDX_W, 8, backing-store index width; there are 2^IDX_W entries.
- LATENCY, 4, cycles from request acceptance to rsp_valid; legal range 1 to 255.

Ports:
- clk  in  1  clock, rising edge.
- reset  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_write  in  1  1 = write block, 0 = read block.
- req_addr  in  ADDR_W  byte address of the request.
- req_wdata  in  DATA_W  write data (ignored on reads).
- rsp_valid  out  1  response present.
- rsp_ready  in  1  cache accepts the response.
- rsp_write  out  1  echo of the accepted req_write.
- rsp_addr  out  ADDR_W  echo of the accepted req_addr.
- rsp_rdata  out  DATA_W  read data, or echo of the write data on writes.
- num_mem_reads  out  12  accepted read requests, saturating.
- num_mem_writes  out  12  accepted write requests, saturating.

Behaviour:
- Reset (reset=0, asynchronous):
  - State goes to IDLE.
  - req_ready=0, rsp_valid=0, rsp_write=0, rsp_addr=0, rsp_rdata=0.
  - Both counters cleared to 0.
  - All per-entry written bits cleared.
  - Any in-flight request is dropped without a response.
- req_ready is a registered output. It rises on the first clk edge after reset deasserts. It is 1 only in IDLE.
- Backing store:
  - Index = req_addr[BLOCK_OFFSET +: IDX_W]. There is no tag check; aliasing addresses share an entry.
  - Each entry carries a written bit.
  - A read of an entry whose written bit is 0 returns (req_addr >> BLOCK_OFFSET), zero-extended or truncated to DATA_W.
  - A read of an entry whose written bit is 1 returns the stored data.
- State machine IDLE -> BUSY -> RESP -> IDLE.
- IDLE:
  - On req_valid && req_ready at edge N, latch req_write, req_addr and req_wdata.
  - Load cnt = LATENCY-1 and go to BUSY.
  - Increment num_mem_reads or num_mem_writes at edge N. Each counter holds at 4095 once it reaches it.
- BUSY:
  - If cnt != 0, decrement cnt.
  - If cnt == 0, perform the memory access and go to RESP.
    - Write: store the data, set the written bit, rsp_rdata = latched wdata.
    - Read: capture rsp_rdata.
  - rsp_valid therefore rises at edge N+LATENCY. With LATENCY=1 it rises on the edge after acceptance.
- RESP:
  - rsp_valid=1. rsp_write, rsp_addr and rsp_rdata stay stable until rsp_ready=1.
  - On handshake go to IDLE. rsp_valid falls and req_ready rises on the same edge.
  - A new request is never accepted in the same cycle as a response handshake, so at most one request is outstanding.
- req_valid while req_ready=0 is ignored and has no side effects. The requester must hold the request.
- Changes on req_* during BUSY or RESP have no effect.
- Reads and writes in BUSY affect only the latched request's entry.

Test Plan:
- Reset then idle:
  - reset=0 for 5 cycles -> all outputs 0.
  - Release reset -> req_ready=1 after the first edge; counters remain 0.
- Cold read, LATENCY=4:
  - Read 48'h7fff493822b0 accepted at edge N.
  - Required: rsp_valid=1 exactly at edge N+4; rsp_rdata=64'h1fffd24e08a; rsp_addr echoes the request; num_mem_reads=1.
- Write then aliased read:
  - Write 48'h7fff493822a8 with data 64'hdeadbeefcafef00d (index 8'h8a).
  - Then read 48'h7fff493822b0.
  - Required: read returns 64'hdeadbeefcafef00d; num_mem_writes=1, num_mem_reads=1.
- Back-pressure:
  - Read 48'h7f3035f6a7c0 with rsp_ready held 0 for 10 cycles.
  - Required: rsp_valid stays high and rsp_rdata stays 64'h1fcc0d7da9f throughout; req_ready=0 throughout; req_valid pulses during the stall are not counted.
- Reset mid-operation:
  - Assert reset 2 cycles after acceptance.
  - Required: rsp_valid never asserts; counters read 0; a prior write is forgotten, so a read of 48'h7fff493822b0 returns 64'h1fffd24e08a.
- Saturation and LATENCY=1:
  - 4100 back-to-back reads with rsp_ready=1.
  - Required: each response arrives 1 edge after acceptance; num_mem_reads saturates at 12'hfff.

Source files
------------

// File: rtl/main_mem_responder.sv
// Next-level memory model on the cache miss side: accepts one block read or write
// at a time and returns a response a fixed LATENCY cycles after acceptance.
module main_mem_responder #(
  parameter int ADDR_W       = 48,
  parameter int DATA_W       = 64,
  parameter int BLOCK_OFFSET = 6,
  parameter int IDX_W        = 8,
  parameter int LATENCY      = 4
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic              rsp_write,
  output logic [ADDR_W-1:0] rsp_addr,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic [11:0]       num_mem_reads,
  output logic [11:0]       num_mem_writes
);

  localparam int ENTRIES = 1 << IDX_W;

  typedef enum logic [1:0] {IDLE, BUSY, RESP} state_t;

  state_t             state, state_next;
  logic [7:0]         cnt;
  logic [DATA_W-1:0]  lat_wdata;
  logic [DATA_W-1:0]  mem [ENTRIES];
  logic [ENTRIES-1:0] written;
  logic [IDX_W-1:0]   acc_idx;
  logic               accept;
  logic               access;

  // rsp_write/rsp_addr double as the latched request, so the access uses them.
  assign accept  = (state == IDLE) && req_valid && req_ready;
  assign access  = (state == BUSY) && (cnt == 8'd0);
  assign acc_idx = rsp_addr[BLOCK_OFFSET +: IDX_W];

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (accept) state_next = BUSY;
      BUSY:    if (cnt == 8'd0) state_next = RESP;
      RESP:    if (rsp_ready) state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) state <= IDLE;
    else        state <= state_next;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      req_ready      <= 1'b0;
      rsp_valid      <= 1'b0;
      rsp_write      <= 1'b0;
      rsp_addr       <= '0;
      rsp_rdata      <= '0;
      lat_wdata      <= '0;
      cnt            <= 8'd0;
      num_mem_reads  <= 12'd0;
      num_mem_writes <= 12'd0;
      written        <= '0;
    end else begin
      req_ready <= (state_next == IDLE);
      rsp_valid <= (state_next == RESP);
      if (accept) begin
        rsp_write <= req_write;
        rsp_addr  <= req_addr;
        lat_wdata <= req_wdata;
        cnt       <= 8'(LATENCY - 1);
        if (req_write) begin
          if (num_mem_writes != 12'hfff) num_mem_writes <= num_mem_writes + 12'd1;
        end else begin
          if (num_mem_reads != 12'hfff) num_mem_reads <= num_mem_reads + 12'd1;
        end
      end else if ((state == BUSY) && (cnt != 8'd0)) begin
        cnt <= cnt - 8'd1;
      end
      // Unwritten entries read back the block number so cold data is traceable.
      if (access) begin
        if (rsp_write) begin
          written[acc_idx] <= 1'b1;
          rsp_rdata        <= lat_wdata;
        end else begin
          rsp_rdata <= written[acc_idx] ? mem[acc_idx]
                                        : DATA_W'(rsp_addr >> BLOCK_OFFSET);
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (access && rsp_write) mem[acc_idx] <= lat_wdata;
  end

endmodule

// File: tb/tb_main_mem_responder.sv
// Directed self-checking bench for main_mem_responder: one LATENCY=4 instance for
// functional cases and one LATENCY=1 instance for back-to-back saturation.
module tb_main_mem_responder;

  logic        clk = 1'b0;
  logic        reset = 1'b0;

  logic        req_valid = 1'b0;
  logic        req_write = 1'b0;
  logic [47:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        rsp_ready = 1'b1;
  logic        req_ready;
  logic        rsp_valid;
  logic        rsp_write;
  logic [47:0] rsp_addr;
  logic [63:0] rsp_rdata;
  logic [11:0] num_mem_reads;
  logic [11:0] num_mem_writes;

  logic        req_valid_b = 1'b0;
  logic [47:0] req_addr_b = '0;
  logic        req_ready_b;
  logic        rsp_valid_b;
  logic        rsp_write_b;
  logic [47:0] rsp_addr_b;
  logic [63:0] rsp_rdata_b;
  logic [11:0] num_mem_reads_b;
  logic [11:0] num_mem_writes_b;

  int num_checks = 0;
  int num_fails  = 0;
  int lat;
  int guard;
  int exp_count;

  always #5 clk = ~clk;

  main_mem_responder #(.LATENCY(4)) dut_a (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
    .req_addr(req_addr), .req_wdata(req_wdata),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_write(rsp_write),
    .rsp_addr(rsp_addr), .rsp_rdata(rsp_rdata),
    .num_mem_reads(num_mem_reads), .num_mem_writes(num_mem_writes)
  );

  main_mem_responder #(.LATENCY(1)) dut_b (
    .clk(clk), .reset(reset),
    .req_valid(req_valid_b), .req_ready(req_ready_b), .req_write(1'b0),
    .req_addr(req_addr_b), .req_wdata(64'd0),
    .rsp_valid(rsp_valid_b), .rsp_ready(1'b1), .rsp_write(rsp_write_b),
    .rsp_addr(rsp_addr_b), .rsp_rdata(rsp_rdata_b),
    .num_mem_reads(num_mem_reads_b), .num_mem_writes(num_mem_writes_b)
  );

  task automatic checkOutput(input string tag, input logic [63:0] observed,
                             input logic [63:0] expected);
    num_checks++;
    assert (observed === expected) else begin
      num_fails++;
      $error("[TB] FAIL %s: observed %h expected %h", tag, observed, expected);
    end
  endtask

  // Called just after a clock edge; returns edges from acceptance to rsp_valid.
  task automatic applyStimulus(input logic wr, input logic [47:0] addr,
                               input logic [63:0] wdata, output int edges);
    int waited = 0;
    while (!req_ready && waited < 50) begin
      @(posedge clk); #1;
      waited++;
    end
    checkOutput("reqReadyWait", {63'd0, req_ready}, 64'd1);
    req_valid = 1'b1;
    req_write = wr;
    req_addr  = addr;
    req_wdata = wdata;
    @(posedge clk); #1;
    req_valid = 1'b0;
    edges = 0;
    while (!rsp_valid && edges < 300) begin
      @(posedge clk); #1;
      edges++;
    end
  endtask

  task automatic applyReset();
    reset = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
    // Reset held, then released
    repeat (5) @(posedge clk);
    #1;
    checkOutput("rstReqReady",  {63'd0, req_ready}, 64'd0);
    checkOutput("rstRspValid",  {63'd0, rsp_valid}, 64'd0);
    checkOutput("rstRspWrite",  {63'd0, rsp_write}, 64'd0);
    checkOutput("rstRspAddr",   {16'd0, rsp_addr}, 64'd0);
    checkOutput("rstRspRdata",  rsp_rdata, 64'd0);
    checkOutput("rstReads",     {52'd0, num_mem_reads}, 64'd0);
    checkOutput("rstWrites",    {52'd0, num_mem_writes}, 64'd0);
    reset = 1'b1;
    #1;
    checkOutput("readyBeforeEdge", {63'd0, req_ready}, 64'd0);
    @(posedge clk); #1;
    checkOutput("readyAfterEdge", {63'd0, req_ready}, 64'd1);
    checkOutput("idleReads",      {52'd0, num_mem_reads}, 64'd0);
    checkOutput("idleWrites",     {52'd0, num_mem_writes}, 64'd0);

    // Cold read
    applyStimulus(1'b0, 48'h7fff493822b0, 64'd0, lat);
    checkOutput("coldLatency", 64'(lat), 64'd4);
    checkOutput("coldRdata",   rsp_rdata, 64'h1fffd24e08a);
    checkOutput("coldAddr",    {16'd0, rsp_addr}, 64'h7fff493822b0);
    checkOutput("coldWrite",   {63'd0, rsp_write}, 64'd0);
    checkOutput("coldReads",   {52'd0, num_mem_reads}, 64'd1);
    checkOutput("coldWrites",  {52'd0, num_mem_writes}, 64'd0);

    // Write then aliased read
    applyReset();
    applyStimulus(1'b1, 48'h7fff493822a8, 64'hdeadbeefcafef00d, lat);
    checkOutput("wrLatency", 64'(lat), 64'd4);
    checkOutput("wrEcho",    rsp_rdata, 64'hdeadbeefcafef00d);
    checkOutput("wrFlag",    {63'd0, rsp_write}, 64'd1);
    checkOutput("wrWrites",  {52'd0, num_mem_writes}, 64'd1);
    applyStimulus(1'b0, 48'h7fff493822b0, 64'd0, lat);
    checkOutput("aliasLatency", 64'(lat), 64'd4);
    checkOutput("aliasRdata",   rsp_rdata, 64'hdeadbeefcafef00d);
    checkOutput("aliasAddr",    {16'd0, rsp_addr}, 64'h7fff493822b0);
    checkOutput("aliasReads",   {52'd0, num_mem_reads}, 64'd1);
    checkOutput("aliasWrites",  {52'd0, num_mem_writes}, 64'd1);

    // Back-pressure with ignored request pulses
    @(posedge clk); #1;
    rsp_ready = 1'b0;
    applyStimulus(1'b0, 48'h7f3035f6a7c0, 64'd0, lat);
    checkOutput("bpLatency", 64'(lat), 64'd4);
    for (int i = 0; i < 10; i++) begin
      req_valid = i[0] ? 1'b0 : 1'b1;
      req_write = i[1];
      req_addr  = 48'h123456789ac0;
      @(posedge clk); #1;
      req_valid = 1'b0;
      checkOutput("bpRspValid", {63'd0, rsp_valid}, 64'd1);
      checkOutput("bpRdata",    rsp_rdata, 64'h1fcc0d7da9f);
      checkOutput("bpAddr",     {16'd0, rsp_addr}, 64'h7f3035f6a7c0);
      checkOutput("bpReqReady", {63'd0, req_ready}, 64'd0);
    end
    checkOutput("bpReads",  {52'd0, num_mem_reads}, 64'd2);
    checkOutput("bpWrites", {52'd0, num_mem_writes}, 64'd1);
    rsp_ready = 1'b1;
    @(posedge clk); #1;
    checkOutput("bpRelease",  {63'd0, rsp_valid}, 64'd0);
    checkOutput("bpReadyBack", {63'd0, req_ready}, 64'd1);

    // Reset two cycles after acceptance
    req_valid = 1'b1;
    req_write = 1'b0;
    req_addr  = 48'h7f3035f6a7c0;
    @(posedge clk); #1;
    req_valid = 1'b0;
    checkOutput("midAccepted", {52'd0, num_mem_reads}, 64'd3);
    @(posedge clk);
    @(posedge clk); #1;
    reset = 1'b0;
    #1;
    checkOutput("midReads",    {52'd0, num_mem_reads}, 64'd0);
    checkOutput("midWrites",   {52'd0, num_mem_writes}, 64'd0);
    checkOutput("midReqReady", {63'd0, req_ready}, 64'd0);
    for (int i = 0; i < 6; i++) begin
      @(posedge clk); #1;
      checkOutput("midNoRsp", {63'd0, rsp_valid}, 64'd0);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checkOutput("midNoRspAfter", {63'd0, rsp_valid}, 64'd0);
    applyStimulus(1'b0, 48'h7fff493822b0, 64'd0, lat);
    checkOutput("forgotLatency", 64'(lat), 64'd4);
    checkOutput("forgotRdata",   rsp_rdata, 64'h1fffd24e08a);
    checkOutput("forgotReads",   {52'd0, num_mem_reads}, 64'd1);

    // LATENCY=1 back-to-back reads into saturation
    for (int i = 0; i < 4100; i++) begin
      guard = 0;
      while (!req_ready_b && guard < 20) begin
        @(posedge clk); #1;
        guard++;
      end
      req_valid_b = 1'b1;
      req_addr_b  = 48'(i) << 6;
      @(posedge clk); #1;
      req_valid_b = 1'b0;
      lat = 0;
      while (!rsp_valid_b && lat < 20) begin
        @(posedge clk); #1;
        lat++;
      end
      exp_count = (i + 1 < 4095) ? i + 1 : 4095;
      checkOutput("satLatency", 64'(lat), 64'd1);
      checkOutput("satRdata",   rsp_rdata_b, 64'(i));
      checkOutput("satCount",   {52'd0, num_mem_reads_b}, 64'(exp_count));
    end
    checkOutput("satFinal",  {52'd0, num_mem_reads_b}, 64'hfff);
    checkOutput("satWrites", {52'd0, num_mem_writes_b}, 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", num_checks, num_fails);
    $finish;
  end

endmodule
